// File: rtl/led_mod_if.sv
// Board-side bundle for led_mod: switches and pushbuttons in, LEDs and display out.
// master = board/user side that drives inputs, slave = led_mod.
interface led_mod_if;
    logic [7:0] switches;
    logic       bLeft;
    logic       bRight;
    logic [7:0] leds;
    logic [3:0] anodes;
    logic [7:0] SSD;

    modport master (
        output switches, bLeft, bRight,
        input  leds, anodes, SSD
    );

    modport slave (
        input  switches, bLeft, bRight,
        output leds, anodes, SSD
    );
endinterface

// File: rtl/led_mod.sv
// LED pattern register and 4-digit common-anode seven-segment scanner.
// Ports:
//   x1        clock, rising edge
//   bBottom   synchronous active-high reset
//   io.switches  8-bit slide switches (shown on digits 1..0, load source)
//   io.bLeft/bRight  pushbuttons: rotate left/right, both = load switches
//   io.leds   pattern register
//   io.anodes active-low digit enables, bit0 = rightmost
//   io.SSD    active-low segments {dp,g,f,e,d,c,b,a}
// Optional macro LED_MOD_DEBOUNCE_EN adds a per-button stability filter of
// DEBOUNCE_CYC samples between the synchronizer and the edge detector.
module led_mod #(
    parameter int unsigned REFRESH_DIV  = 16,
    parameter int unsigned DEBOUNCE_CYC = 4
) (
    input  logic     x1,
    input  logic     bBottom,
    led_mod_if.slave io
);

    localparam int unsigned CW = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] CntLast = CW'(REFRESH_DIV - 1);

    // bit0 = left button, bit1 = right button
    logic [1:0] sync1_q;
    logic [1:0] sync2_q;
    logic [1:0] lvl_prev_q;
    logic [1:0] pulse_q;
    logic [1:0] btn_lvl;

    logic [7:0]    pattern_q;
    logic [CW-1:0] cnt_q;
    logic [1:0]    idx_q;
    logic [3:0]    anodes_q;
    logic [7:0]    ssd_q;
    logic [3:0]    nibble;

    function automatic logic [7:0] seg_hex(input logic [3:0] n);
        logic [7:0] s;
        case (n)
            4'h0:    s = 8'hC0;
            4'h1:    s = 8'hF9;
            4'h2:    s = 8'hA4;
            4'h3:    s = 8'hB0;
            4'h4:    s = 8'h99;
            4'h5:    s = 8'h92;
            4'h6:    s = 8'h82;
            4'h7:    s = 8'hF8;
            4'h8:    s = 8'h80;
            4'h9:    s = 8'h90;
            4'hA:    s = 8'h88;
            4'hB:    s = 8'h83;
            4'hC:    s = 8'hC6;
            4'hD:    s = 8'hA1;
            4'hE:    s = 8'h86;
            default: s = 8'h8E;
        endcase
        return s;
    endfunction

    // Two-stage synchronizer; reset clears it so a button still held at
    // release is seen as a fresh rising edge.
    always_ff @(posedge x1) begin
        if (bBottom) begin
            sync1_q <= 2'b00;
            sync2_q <= 2'b00;
        end else begin
            sync1_q <= {io.bRight, io.bLeft};
            sync2_q <= sync1_q;
        end
    end

`ifdef LED_MOD_DEBOUNCE_EN
    localparam int unsigned DW = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [DW-1:0] DbLast = DW'(DEBOUNCE_CYC - 1);

    logic [DW-1:0] db_cnt_q [2];
    logic [1:0]    db_q;

    // The level only flips after DEBOUNCE_CYC consecutive differing samples;
    // any sample matching the current level restarts the count.
    always_ff @(posedge x1) begin
        if (bBottom) begin
            db_q <= 2'b00;
            for (int b = 0; b < 2; b++) begin
                db_cnt_q[b] <= '0;
            end
        end else begin
            for (int b = 0; b < 2; b++) begin
                if (sync2_q[b] == db_q[b]) begin
                    db_cnt_q[b] <= '0;
                end else if (db_cnt_q[b] == DbLast) begin
                    db_q[b]     <= sync2_q[b];
                    db_cnt_q[b] <= '0;
                end else begin
                    db_cnt_q[b] <= db_cnt_q[b] + 1'b1;
                end
            end
        end
    end

    assign btn_lvl = db_q;
`else
    logic unused_dbc;
    assign unused_dbc = DEBOUNCE_CYC[0];
    assign btn_lvl    = sync2_q;
`endif

    // Registered rising-edge pulses, one cycle wide per press.
    always_ff @(posedge x1) begin
        if (bBottom) begin
            lvl_prev_q <= 2'b00;
            pulse_q    <= 2'b00;
        end else begin
            lvl_prev_q <= btn_lvl;
            pulse_q    <= btn_lvl & ~lvl_prev_q;
        end
    end

    always_ff @(posedge x1) begin
        if (bBottom) begin
            pattern_q <= 8'h01;
        end else begin
            case (pulse_q)
                2'b01:   pattern_q <= {pattern_q[6:0], pattern_q[7]};
                2'b10:   pattern_q <= {pattern_q[0], pattern_q[7:1]};
                2'b11:   pattern_q <= io.switches;
                default: pattern_q <= pattern_q;
            endcase
        end
    end

    always_comb begin
        nibble = io.switches[3:0];
        case (idx_q)
            2'd1:    nibble = io.switches[7:4];
            2'd2:    nibble = pattern_q[3:0];
            2'd3:    nibble = pattern_q[7:4];
            default: nibble = io.switches[3:0];
        endcase
    end

    // Outputs are registered from the current index, so each digit is
    // driven for exactly REFRESH_DIV clocks starting the clock after reset.
    always_ff @(posedge x1) begin
        if (bBottom) begin
            cnt_q    <= '0;
            idx_q    <= 2'd0;
            anodes_q <= 4'b1111;
            ssd_q    <= 8'hFF;
        end else begin
            if (cnt_q == CntLast) begin
                cnt_q <= '0;
                idx_q <= idx_q + 2'd1;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
            anodes_q <= ~(4'b0001 << idx_q);
            ssd_q    <= seg_hex(nibble);
        end
    end

    assign io.leds   = pattern_q;
    assign io.anodes = anodes_q;
    assign io.SSD    = ssd_q;

endmodule

// File: tb/tb_led_mod.sv
// Scoreboard bench for led_mod: button presses push expected LED values,
// observed LED changes pop and compare; display scan checked per clock.
module tb_led_mod;

    logic x1 = 1'b0;
    logic bBottom;

    led_mod_if io ();

    led_mod #(
        .REFRESH_DIV (4),
        .DEBOUNCE_CYC(4)
    ) dut (
        .x1     (x1),
        .bBottom(bBottom),
        .io     (io)
    );

    always #5 x1 = ~x1;

    int checks = 0;
    int errors = 0;

    logic [7:0] sb [$];
    logic [7:0] model;
    logic [7:0] hex_tbl [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    task automatic tick();
        @(posedge x1);
        #1;
    endtask

    task automatic apply_reset();
        io.bLeft  = 1'b0;
        io.bRight = 1'b0;
        bBottom   = 1'b1;
        tick();
        bBottom = 1'b0;
        model   = 8'h01;
    endtask

    // Holds the buttons for 'hold' clocks, then watches a bounded window
    // and reports how many times leds changed and the first new value.
    task automatic do_press(input logic l, input logic r, input int hold,
                            output int nchg, output logic [7:0] first);
        logic [7:0] prev;
        nchg      = 0;
        first     = 8'h00;
        prev      = io.leds;
        io.bLeft  = l;
        io.bRight = r;
        for (int i = 0; i < hold + 12; i++) begin
            tick();
            if (i == hold - 1) begin
                io.bLeft  = 1'b0;
                io.bRight = 1'b0;
            end
            if (io.leds !== prev) begin
                nchg++;
                if (nchg == 1) first = io.leds;
                prev = io.leds;
            end
        end
    endtask

    task automatic test_reset();
        int n;
        logic [7:0] f, e;
        io.switches = 8'hFF;
        io.bLeft    = 1'b1;
        io.bRight   = 1'b1;
        bBottom     = 1'b1;
        tick();
        checks++;
        if (io.leds !== 8'h01)
            $display("FAIL reset_leds got %h want 01", io.leds);
        if (io.leds !== 8'h01) errors++;
        checks++;
        if (io.anodes !== 4'b1111 || io.SSD !== 8'hFF) begin
            $display("FAIL reset_disp got %b/%h want 1111/FF", io.anodes, io.SSD);
            errors++;
        end
        bBottom     = 1'b0;
        io.switches = 8'h00;
        tick();
        checks++;
        if (io.anodes !== 4'b1110 || io.SSD !== 8'hC0 || io.leds !== 8'h01) begin
            $display("FAIL release_first got %b/%h/%h want 1110/C0/01",
                     io.anodes, io.SSD, io.leds);
            errors++;
        end
        model = 8'h00;
        sb.push_back(model);
        do_press(1'b1, 1'b1, 3, n, f);
        e = sb.pop_front();
        checks++;
        if (f !== e) begin
            $display("FAIL held_load got %h want %h", f, e);
            errors++;
        end
        checks++;
        if (n !== 1) begin
            $display("FAIL held_load_count got %0d want 1", n);
            errors++;
        end
    endtask

    task automatic test_rotate_right();
        int n;
        logic [7:0] f, e;
        apply_reset();
        for (int k = 0; k < 8; k++) begin
            model = {model[0], model[7:1]};
            sb.push_back(model);
            do_press(1'b0, 1'b1, 6, n, f);
            e = sb.pop_front();
            checks++;
            if (f !== e || n !== 1) begin
                $display("FAIL rot_right[%0d] got %h x%0d want %h x1", k, f, n, e);
                errors++;
            end
        end
        checks++;
        if (io.leds !== 8'h01) begin
            $display("FAIL rot_right_wrap got %h want 01", io.leds);
            errors++;
        end
    endtask

    task automatic test_rotate_left();
        int n;
        logic [7:0] f, e;
        for (int k = 0; k < 8; k++) begin
            model = {model[6:0], model[7]};
            sb.push_back(model);
            do_press(1'b1, 1'b0, 6, n, f);
            e = sb.pop_front();
            checks++;
            if (f !== e || n !== 1) begin
                $display("FAIL rot_left[%0d] got %h x%0d want %h x1", k, f, n, e);
                errors++;
            end
        end
        checks++;
        if (io.leds !== 8'h01) begin
            $display("FAIL rot_left_wrap got %h want 01", io.leds);
            errors++;
        end
    endtask

    task automatic test_hold();
        int n;
        logic [7:0] f, e;
        model = {model[6:0], model[7]};
        sb.push_back(model);
        do_press(1'b1, 1'b0, 100, n, f);
        e = sb.pop_front();
        checks++;
        if (f !== e || n !== 1) begin
            $display("FAIL hold_left got %h x%0d want %h x1", f, n, e);
            errors++;
        end
    endtask

    task automatic test_load();
        int n;
        int d;
        logic [7:0] f, e, es;
        io.switches = 8'hA5;
        model       = io.switches;
        sb.push_back(model);
        do_press(1'b1, 1'b1, 6, n, f);
        e = sb.pop_front();
        checks++;
        if (f !== e || n !== 1) begin
            $display("FAIL load_both got %h x%0d want %h x1", f, n, e);
            errors++;
        end
        for (int k = 0; k < 16; k++) begin
            tick();
            d = 0;
            for (int b = 0; b < 4; b++)
                if (io.anodes[b] === 1'b0) d = b;
            case (d)
                0:       es = hex_tbl[io.switches[3:0]];
                1:       es = hex_tbl[io.switches[7:4]];
                2:       es = hex_tbl[model[3:0]];
                default: es = hex_tbl[model[7:4]];
            endcase
            checks++;
            if ($countones(~io.anodes) != 1 || io.SSD !== es) begin
                $display("FAIL load_scan[%0d] got %b/%h want one-low/%h",
                         k, io.anodes, io.SSD, es);
                errors++;
            end
        end
    endtask

    task automatic test_reset_abort();
        io.bRight = 1'b1;
        tick();
        tick();
        tick();
        bBottom   = 1'b1;
        io.bRight = 1'b0;
        tick();
        checks++;
        if (io.leds !== 8'h01 || io.anodes !== 4'b1111 || io.SSD !== 8'hFF) begin
            $display("FAIL abort_reset got %h/%b/%h want 01/1111/FF",
                     io.leds, io.anodes, io.SSD);
            errors++;
        end
        bBottom = 1'b0;
        model   = 8'h01;
        for (int k = 0; k < 10; k++) tick();
        checks++;
        if (io.leds !== model) begin
            $display("FAIL abort_discard got %h want %h", io.leds, model);
            errors++;
        end
    endtask

    task automatic test_scan();
        logic [3:0] ea;
        logic [7:0] es;
        io.switches = 8'h3C;
        apply_reset();
        for (int k = 0; k < 16; k++) begin
            tick();
            ea = ~(4'b0001 << (k / 4));
            case (k / 4)
                0:       es = 8'hC6;
                1:       es = 8'hB0;
                2:       es = 8'hF9;
                default: es = 8'hC0;
            endcase
            checks++;
            if (io.anodes !== ea || io.SSD !== es) begin
                $display("FAIL scan[%0d] got %b/%h want %b/%h",
                         k, io.anodes, io.SSD, ea, es);
                errors++;
            end
        end
        tick();
        io.switches = 8'h39;
        tick();
        checks++;
        if (io.anodes !== 4'b1110 || io.SSD !== 8'h90) begin
            $display("FAIL sw_follow got %b/%h want 1110/90", io.anodes, io.SSD);
            errors++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        bBottom     = 1'b0;
        io.bLeft    = 1'b0;
        io.bRight   = 1'b0;
        io.switches = 8'h00;
        test_reset();
        test_rotate_right();
        test_rotate_left();
        test_hold();
        test_load();
        test_reset_abort();
        test_scan();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
